inst_fetch_unit: RTL and testbench

// - Instruction fetch stage of KGP-RISC; sits directly upstream of the instruction decoder.
// - Holds the PC and issues one word request at a time to instruction memory (variable latency, req/gnt + rvalid).
// - Presents {inst, inst_pc} to the decoder under a valid/ready handshake.
// - Applies branch/jump redirects from downstream and discards wrong-path responses.

---
 rtl/inst_fetch_unit.sv | 103 ++++++++++
 tb/tb_inst_fetch_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one imem request at a time and
// hands {inst, inst_pc} to the decoder, squashing wrong-path responses on redirect.
module inst_fetch_unit #(
    parameter int                 ADDR_W   = 32,
    parameter logic [ADDR_W-1:0]  RESET_PC = '0,
    parameter int                 PC_INC   = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [31:0]       imem_rdata,
    output logic [31:0]       inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              dec_ready,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              align_err,
    output logic [15:0]       fetch_cnt
);

    typedef enum logic [1:0] {
        FETCH,
        WAIT,
        HOLD
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              drop;
    logic [ADDR_W-1:0] target;

    assign target     = {redirect_pc[ADDR_W-1:2], 2'b00};
    assign imem_req   = (state == FETCH);
    assign imem_addr  = pc;
    assign inst_valid = (state == HOLD);

    // NOTE: every register below is assigned with <= so all of them see the
    // pre-edge values of state/pc/drop regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            drop      <= 1'b0;
            inst      <= '0;
            inst_pc   <= '0;
            align_err <= 1'b0;
            fetch_cnt <= '0;
        end else if (redirect_valid) begin
            pc        <= target;
            align_err <= align_err | (|redirect_pc[1:0]);
            // A request already granted for the old path must have its response squashed.
            case (state)
                FETCH: begin
                    if (imem_gnt) begin
                        state <= WAIT;
                        drop  <= 1'b1;
                    end
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        state <= FETCH;
                        drop  <= 1'b0;
                    end else begin
                        drop  <= 1'b1;
                    end
                end
                HOLD:    state <= FETCH;
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    if (imem_gnt) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        if (drop) begin
                            drop  <= 1'b0;
                            state <= FETCH;
                        end else begin
                            inst    <= imem_rdata;
                            inst_pc <= pc;
                            pc      <= pc + ADDR_W'(PC_INC);
                            state   <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (dec_ready) begin
                        fetch_cnt <= fetch_cnt + 16'd1;
                        state     <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Self-checking bench for inst_fetch_unit: the bench plays instruction memory and
// tracks the expected instruction stream at transaction level.
module tb_inst_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_valid;
    logic        dec_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        align_err;
    logic [15:0] fetch_cnt;

    always #5 clk = ~clk;

    inst_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .dec_ready      (dec_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .align_err      (align_err),
        .fetch_cnt      (fetch_cnt)
    );

    int checks = 0;
    int errors = 0;

    // Transaction-level view: next address in program order, the single
    // outstanding memory request, and the instruction waiting for the decoder.
    logic [31:0] exp_pc;
    bit          busy;
    bit          killed;
    logic [31:0] req_addr;
    bit          holding;
    logic [31:0] hold_inst;
    logic [31:0] hold_pc;
    int          delivered;
    bit          exp_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst            = 1'b1;
        imem_gnt       = 1'b1;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'hDEAD_BEEF;
        dec_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0081;
        @(negedge clk);
        check("rst_inst",       inst,              32'h0);
        check("rst_inst_pc",    inst_pc,           32'h0);
        check("rst_inst_valid", 32'(inst_valid),   32'h0);
        check("rst_fetch_cnt",  32'(fetch_cnt),    32'h0);
        check("rst_align_err",  32'(align_err),    32'h0);
        rst            = 1'b0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        dec_ready      = 1'b0;
        redirect_valid = 1'b0;
        exp_pc    = 32'h0;
        busy      = 1'b0;
        killed    = 1'b0;
        holding   = 1'b0;
        delivered = 0;
        exp_err   = 1'b0;
    endtask

    // One clock: compare outputs against the model, drive inputs, then advance
    // the model by what those inputs mean at the coming edge.
    task automatic cycle(input bit g, input bit rv, input logic [31:0] rd, input bit rdy,
                         input bit redir, input logic [31:0] tgt);
        bit req_now;
        @(negedge clk);
        req_now = !(busy || holding);
        check("inst_valid", 32'(inst_valid), 32'(holding));
        check("imem_req",   32'(imem_req),   32'(req_now));
        check("fetch_cnt",  32'(fetch_cnt),  32'(delivered & 16'hFFFF));
        check("align_err",  32'(align_err),  32'(exp_err));
        if (holding) begin
            check("inst",    inst,    hold_inst);
            check("inst_pc", inst_pc, hold_pc);
        end
        if (req_now) check("imem_addr", imem_addr, exp_pc);

        imem_gnt       = g;
        imem_rvalid    = rv;
        imem_rdata     = rd;
        dec_ready      = rdy;
        redirect_valid = redir;
        redirect_pc    = tgt;

        if (redir) begin
            holding = 1'b0;
            if (busy) begin
                killed = 1'b1;
                if (rv) busy = 1'b0;
            end else if (req_now && g) begin
                busy     = 1'b1;
                killed   = 1'b1;
                req_addr = exp_pc;
            end
            exp_pc  = tgt & ~32'h3;
            exp_err = exp_err | (tgt[1:0] != 2'b00);
        end else if (req_now && g) begin
            busy     = 1'b1;
            killed   = 1'b0;
            req_addr = exp_pc;
        end else if (busy && rv) begin
            busy = 1'b0;
            if (!killed) begin
                holding   = 1'b1;
                hold_inst = rd;
                hold_pc   = req_addr;
                exp_pc    = req_addr + 32'd4;
            end
        end else if (holding && rdy) begin
            holding = 1'b0;
            delivered++;
        end
    endtask

    task automatic random_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            bit          g, rv, rdy, redir;
            logic [31:0] tgt;
            g     = ($urandom_range(0, 1) == 1);
            rv    = busy ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0);
            rdy   = ($urandom_range(0, 1) == 1);
            redir = ($urandom_range(0, 9) == 0);
            case ($urandom_range(0, 3))
                0:       tgt = $urandom & 32'h0000_0FFC;
                1:       tgt = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
                2:       tgt = $urandom;
                default: tgt = $urandom & ~32'h3;
            endcase
            cycle(g, rv, $urandom, rdy, redir, tgt);
        end
    endtask

    initial begin
        rst = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
        dec_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
        do_reset();

        // First fetch from reset, delivered with decoder ready.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h04C2_81E5, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Decoder stall for 5 cycles while holding.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h24C2_81E5, 0, 0, 0);
        for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Redirect while waiting; the late response must be dropped.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 1, 32'h100);
        cycle(0, 1, 32'h44C2_81E5, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h1111_0000, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Redirect together with a grant in FETCH.
        cycle(1, 0, 0, 0, 1, 32'h40);
        cycle(0, 1, 32'h2222_0000, 1, 0, 0);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h3333_0000, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        // Misaligned redirect in HOLD kills the held instruction.
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h5555_0000, 0, 0, 0);
        cycle(0, 0, 0, 1, 1, 32'h102);
        cycle(0, 0, 0, 0, 0, 0);
        // PC wrap at the top of the address space.
        cycle(0, 0, 0, 0, 1, 32'hFFFF_FFFC);
        cycle(1, 0, 0, 0, 0, 0);
        cycle(0, 1, 32'h6666_0000, 0, 0, 0);
        cycle(0, 0, 0, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        // Reset during WAIT; the orphaned response must be ignored.
        cycle(1, 0, 0, 0, 0, 0);
        do_reset();
        cycle(0, 1, 32'h7777_0000, 1, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        random_cycles(3000);
        do_reset();
        random_cycles(3000);
        cycle(0, 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
